// File: rtl/skip_divider_pkg.sv
// Shared types and constants for the skip-subtractor based divider.
// No logic of its own; pure declarations.
// No flow control; consumed by skip_divider and skip_sub.
package skip_divider_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width and skip-block size.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_BLK   = 4;

  // Quotient reported for a zero divisor (all ones).
  localparam logic [DEF_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/skip_sub.sv
// Combinational W-bit carry-skip subtractor: diff = a - b via a + ~b + 1.
// Latency: zero cycles (purely combinational).
// No flow control; carry_out=1 means no borrow (a >= b).
module skip_sub
  import skip_divider_pkg::*;
#(
  parameter int W   = DEF_WIDTH + 1,
  parameter int BLK = DEF_BLK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         carry_out
);

  // Pad to whole blocks with at least one spare bit above W so the carry
  // into bit W is always an ordinary internal ripple carry.
  localparam int NBLK = (W + BLK) / BLK;
  localparam int PW   = NBLK * BLK;

  logic [W-1:0]  b_inv;
  logic [PW-1:0] ap;
  logic [PW-1:0] bp;
  logic [PW-1:0] p;
  logic [PW-1:0] g;
  logic [PW-1:0] c;
  logic [PW-1:0] s;
  logic [NBLK:0] bc;
  logic          unused_bits;

  assign b_inv = ~b;
  assign ap    = PW'(a);
  assign bp    = PW'(b_inv);
  assign p     = ap ^ bp;
  assign g     = ap & bp;

  // Ripple inside each block; a block's carry-out bypasses the ripple
  // when every propagate bit in the block is set.
  always_comb begin
    c     = '0;
    bc    = '0;
    bc[0] = 1'b1;  // the +1 of the two's-complement subtraction
    for (int k = 0; k < NBLK; k++) begin
      c[k*BLK] = bc[k];
      for (int i = 1; i < BLK; i++) begin
        c[k*BLK+i] = g[k*BLK+i-1] | (p[k*BLK+i-1] & c[k*BLK+i-1]);
      end
      bc[k+1] = (&p[k*BLK +: BLK]) ? bc[k]
              : (g[k*BLK+BLK-1] | (p[k*BLK+BLK-1] & c[k*BLK+BLK-1]));
    end
  end

  assign s         = p ^ c;
  assign diff      = s[W-1:0];
  assign carry_out = c[W];

  // Padding sum bits and the top skip carry carry no information.
  assign unused_bits = ^{s[PW-1:W], bc[NBLK]};

endmodule

// File: rtl/skip_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: out_valid WIDTH+1 edges counting the accepting edge; 1 edge for a zero divisor.
// Backpressure: one request in flight; result held stable until out_ready, in_ready only in IDLE.
module skip_divider
  import skip_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK   = DEF_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] DBZ_Q = {WIDTH{DBZ_QUOTIENT[0]}};

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   t_diff;
  logic             no_borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             accept;
  logic             last_iter;
  logic             unused_rtop;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

  skip_sub #(
    .W   (WIDTH + 1),
    .BLK (BLK)
  ) u_sub (
    .a         (r_shift),
    .b         ({1'b0, d_reg}),
    .diff      (t_diff),
    .carry_out (no_borrow)
  );

  assign r_next    = no_borrow ? t_diff : r_shift;
  assign q_next    = {q_reg[WIDTH-2:0], no_borrow};
  assign last_iter = (cnt == LAST);

  // R[WIDTH] is shifted out every step; the restoring step keeps it zero.
  assign unused_rtop = r_reg[WIDTH];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          state_nx = (divisor == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate while busy, publish result on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q_reg       <= dividend;
      d_reg       <= divisor;
      r_reg       <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
      if (divisor == '0) begin
        quotient    <= DBZ_Q;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == BUSY) begin
      q_reg <= q_next;
      r_reg <= r_next;
      cnt   <= cnt + 1'b1;
      if (last_iter) begin
        quotient  <= q_next;
        remainder <= r_next[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_skip_divider.sv
module tb_skip_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks;
  int failures;

  skip_divider #(
    .WIDTH (16),
    .BLK   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dvd;
    logic [15:0] dsr;
    logic [15:0] exp_q;
    logic [15:0] exp_r;
    logic        exp_dbz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, wait for the result, consume it. Returns the result and
  // the number of edges from the accepting edge (inclusive) to out_valid.
  task automatic do_div(input logic [15:0] dvd, input logic [15:0] dsr,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic dbz, output int lat);
    check("req_in_ready", {31'd0, in_ready}, 32'd1);
    dividend = dvd;
    divisor  = dsr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q   = quotient;
    r   = remainder;
    dbz = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_idle_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  vec_t        vecs[$];
  logic [15:0] rq;
  logic [15:0] rr;
  logic        rdbz;
  int          rlat;
  logic        seen;

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    vecs.push_back('{16'd100,   16'd7,     16'd14,     16'd2,      1'b0});
    vecs.push_back('{16'hFFFF,  16'd1,     16'hFFFF,   16'd0,      1'b0});
    vecs.push_back('{16'hFFFF,  16'hFFFF,  16'd1,      16'd0,      1'b0});
    vecs.push_back('{16'd3,     16'd10,    16'd0,      16'd3,      1'b0});
    vecs.push_back('{16'd0,     16'd5,     16'd0,      16'd0,      1'b0});
    vecs.push_back('{16'd5,     16'd0,     16'hFFFF,   16'd5,      1'b1});
    vecs.push_back('{16'd9,     16'd3,     16'd3,      16'd0,      1'b0});
    vecs.push_back('{16'd1000,  16'd3,     16'd333,    16'd1,      1'b0});
    vecs.push_back('{16'h8000,  16'h8000,  16'd1,      16'd0,      1'b0});
    vecs.push_back('{16'hFFFF,  16'd2,     16'h7FFF,   16'd1,      1'b0});
    vecs.push_back('{16'd12345, 16'd123,   16'd100,    16'd45,     1'b0});
    vecs.push_back('{16'hABCD,  16'h0010,  16'h0ABC,   16'h000D,   1'b0});
    vecs.push_back('{16'h7FFF,  16'hFFFF,  16'd0,      16'h7FFF,   1'b0});
    vecs.push_back('{16'd0,     16'd0,     16'hFFFF,   16'd0,      1'b1});

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {31'd0, in_ready},    32'd1);
    check("rst_out_valid", {31'd0, out_valid},   32'd0);
    check("rst_quotient",  {16'd0, quotient},    32'd0);
    check("rst_remainder", {16'd0, remainder},   32'd0);
    check("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    foreach (vecs[i]) begin
      do_div(vecs[i].dvd, vecs[i].dsr, rq, rr, rdbz, rlat);
      check($sformatf("vec%0d_q", i),   {16'd0, rq},   {16'd0, vecs[i].exp_q});
      check($sformatf("vec%0d_r", i),   {16'd0, rr},   {16'd0, vecs[i].exp_r});
      check($sformatf("vec%0d_dbz", i), {31'd0, rdbz}, {31'd0, vecs[i].exp_dbz});
      check($sformatf("vec%0d_lat", i), rlat, vecs[i].exp_dbz ? 32'd1 : 32'd17);
    end

    // Backpressure: hold the 100/7 result while poking in_valid.
    dividend = 16'd100;
    divisor  = 16'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rlat = 1;
    while (!out_valid && rlat < 40) begin
      @(posedge clk); #1;
      rlat++;
    end
    check("bp_lat", rlat, 32'd17);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      dividend = 16'd9;
      divisor  = 16'd3;
      check($sformatf("bp%0d_in_ready", c),  {31'd0, in_ready},    32'd0);
      @(posedge clk); #1;
      check($sformatf("bp%0d_out_valid", c), {31'd0, out_valid},   32'd1);
      check($sformatf("bp%0d_q", c),         {16'd0, quotient},    32'd14);
      check($sformatf("bp%0d_r", c),         {16'd0, remainder},   32'd2);
      check($sformatf("bp%0d_dbz", c),       {31'd0, div_by_zero}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_rel_in_ready",  {31'd0, in_ready},  32'd1);
    check("bp_rel_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_rel_q_kept",    {16'd0, quotient},  32'd14);
    check("bp_rel_r_kept",    {16'd0, remainder}, 32'd2);

    // Reset in the middle of a 1000/3 divide.
    dividend = 16'd1000;
    divisor  = 16'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  {31'd0, in_ready},    32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid},   32'd0);
    check("mid_rst_q",         {16'd0, quotient},    32'd0);
    check("mid_rst_r",         {16'd0, remainder},   32'd0);
    check("mid_rst_dbz",       {31'd0, div_by_zero}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_out_valid", {31'd0, seen}, 32'd0);
    do_div(16'd1000, 16'd3, rq, rr, rdbz, rlat);
    check("after_rst_q",   {16'd0, rq},   32'd333);
    check("after_rst_r",   {16'd0, rr},   32'd1);
    check("after_rst_dbz", {31'd0, rdbz}, 32'd0);
    check("after_rst_lat", rlat,          32'd17);

    // Random sweep against a reference model (nonzero divisors).
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] recon;
      a = 16'($urandom);
      b = (n % 3 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom);
      if (b == 16'd0) b = 16'd1;
      do_div(a, b, rq, rr, rdbz, rlat);
      recon = 32'(rq) * 32'(b) + 32'(rr);
      check($sformatf("rnd%0d_q %0d/%0d", n, a, b), {16'd0, rq}, {16'd0, a / b});
      check($sformatf("rnd%0d_r %0d/%0d", n, a, b), {16'd0, rr}, {16'd0, a % b});
      check($sformatf("rnd%0d_ident", n), {31'd0, (recon == 32'(a)) && (rr < b)}, 32'd1);
      check($sformatf("rnd%0d_dbz", n), {31'd0, rdbz}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
